// File: rtl/clause_store_pkg.sv
// -----------------------------------------------------------------------------
// clause_store_pkg
// Shared definitions for the per-bin clause store:
//   - 2-bit literal encodings (LIT_NONE / LIT_POS / LIT_NEG; 3 is illegal but
//     is stored unchanged)
//   - learnt-insertion FSM state encoding
//   - freeCountWidth(): width of a counter that can hold 0..n
// -----------------------------------------------------------------------------
package clause_store_pkg;

  localparam logic [1:0] LIT_NONE = 2'd0;
  localparam logic [1:0] LIT_POS  = 2'd1;
  localparam logic [1:0] LIT_NEG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // A count of free slots ranges over 0..n, so it needs one bit more than
  // a slot index.
  function automatic int freeCountWidth(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/clause_store_bin_finder.sv
// -----------------------------------------------------------------------------
// lowest_onehot_finder
// Returns a one-hot vector marking the first set bit of i_req, searching
// upward from bit i_start and wrapping around to bit 0. With i_start = 0 it
// is a plain lowest-set-bit finder. Returns all zeros when i_req is zero.
//
// Ports
//   i_req     in  N          request bits
//   i_start   in  $clog2(N)  search start position
//   o_onehot  out N          one-hot winner, 0 if none
// -----------------------------------------------------------------------------
module lowest_onehot_finder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_start,
  output logic [N-1:0]         o_onehot
);

  localparam int IW = $clog2(N);

  logic          w_found;
  logic [IW-1:0] w_idx;

  // Walk the N positions in rotated order; the first request seen wins.
  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(i_start) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clause_store_bin.sv
// -----------------------------------------------------------------------------
// clause_store_bin
// Per-bin clause store: NUM_CLAUSES_A_BIN slots, each holding a length and
// NUM_VARS_A_BIN 2-bit literals, plus per-slot valid and learnt flags.
// Original clauses arrive through the one-hot base write port; learnt clauses
// arrive over a valid/ready handshake and are placed in the lowest free slot
// by a three-state IDLE -> SCAN -> COMMIT sequencer. A registered read port
// returns slot contents one cycle after the request.
//
// Build option
//   CLAUSE_STORE_EVICT_EN  when defined, a full bin still accepts learnt
//                          clauses and overwrites learnt slots round-robin
//                          starting from an eviction pointer.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   wr_i / clause_len_i /
//     clause_lits_i               one-hot base write (slot valid, learnt=0)
//   del_i                         bit-mask invalidate
//   learnt_valid_i / learnt_ready_o /
//     learnt_len_i / learnt_lits_i  learnt clause handshake
//   learnt_done_o / learnt_index_o  commit pulse and one-hot slot written
//   learntc_insert_index_o        one-hot lowest free slot, 0 if full
//   rd_en_i / rd_index_i          read request
//   rd_valid_o / rd_len_o /
//     rd_lits_o / rd_learnt_o     read response, one cycle later
//   free_count_o, full_o, empty_o occupancy status
// -----------------------------------------------------------------------------
module clause_store_bin
  import clause_store_pkg::*;
#(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int NUM_VARS_A_BIN    = 8,
  parameter int WIDTH_C_LEN       = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                  wr_i,
  input  logic [WIDTH_C_LEN-1:0]                        clause_len_i,
  input  logic [2*NUM_VARS_A_BIN-1:0]                   clause_lits_i,
  input  logic [NUM_CLAUSES_A_BIN-1:0]                  del_i,
  input  logic                                          learnt_valid_i,
  output logic                                          learnt_ready_o,
  input  logic [WIDTH_C_LEN-1:0]                        learnt_len_i,
  input  logic [2*NUM_VARS_A_BIN-1:0]                   learnt_lits_i,
  output logic                                          learnt_done_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]                  learnt_index_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]                  learntc_insert_index_o,
  input  logic                                          rd_en_i,
  input  logic [$clog2(NUM_CLAUSES_A_BIN)-1:0]          rd_index_i,
  output logic                                          rd_valid_o,
  output logic [WIDTH_C_LEN-1:0]                        rd_len_o,
  output logic [2*NUM_VARS_A_BIN-1:0]                   rd_lits_o,
  output logic                                          rd_learnt_o,
  output logic [freeCountWidth(NUM_CLAUSES_A_BIN)-1:0]  free_count_o,
  output logic                                          full_o,
  output logic                                          empty_o
);

  localparam int N   = NUM_CLAUSES_A_BIN;
  localparam int IW  = $clog2(N);
  localparam int LW  = 2 * NUM_VARS_A_BIN;
  localparam int FCW = freeCountWidth(N);

  // Slot storage
  logic [N-1:0]             r_validMap;
  logic [N-1:0]             r_learntMap;
  logic [WIDTH_C_LEN-1:0]   r_lenMem  [N];
  logic [LW-1:0]            r_litsMem [N];

  // Insertion sequencer
  state_e                   r_state;
  logic [WIDTH_C_LEN-1:0]   r_latLen;
  logic [LW-1:0]            r_latLits;
  logic [N-1:0]             r_target;

  // Read port
  logic                     r_rdValid;
  logic [WIDTH_C_LEN-1:0]   r_rdLen;
  logic [LW-1:0]            r_rdLits;
  logic                     r_rdLearnt;

  logic [N-1:0]             w_freeOneHot;
  logic [FCW-1:0]           w_freeCount;
  logic                     w_evictAllowed;
  logic                     w_conflict;
  logic                     w_commit;

  lowest_onehot_finder #(.N(N)) u_freeFinder (
    .i_req    (~r_validMap),
    .i_start  ({IW{1'b0}}),
    .o_onehot (w_freeOneHot)
  );

`ifdef CLAUSE_STORE_EVICT_EN
  logic [IW-1:0]            r_evictPtr;
  logic                     r_targetEvict;
  logic [N-1:0]             w_victimOneHot;
  logic [IW-1:0]            w_targetIdx;
  logic [IW-1:0]            w_nextPtr;

  assign w_evictAllowed = 1'b1;

  // Victims are valid learnt slots; original clauses are never evicted.
  lowest_onehot_finder #(.N(N)) u_victimFinder (
    .i_req    (r_validMap & r_learntMap),
    .i_start  (r_evictPtr),
    .o_onehot (w_victimOneHot)
  );

  // Binary index of the current target, used to advance the pointer past it.
  always_comb begin
    w_targetIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_target[i]) w_targetIdx = IW'(i);
    end
    w_nextPtr = (w_targetIdx == IW'(N - 1)) ? '0 : w_targetIdx + 1'b1;
  end
`else
  assign w_evictAllowed = 1'b0;
`endif

  // Occupancy status straight from the registered valid map.
  always_comb begin
    w_freeCount = '0;
    for (int i = 0; i < N; i++) begin
      w_freeCount = w_freeCount + FCW'(!r_validMap[i]);
    end
  end

  assign free_count_o           = w_freeCount;
  assign full_o                 = (w_freeCount == '0);
  assign empty_o                = (w_freeCount == FCW'(N));
  assign learntc_insert_index_o = w_freeOneHot;

  // A base write or delete touching the commit target wins over the commit;
  // the learnt clause is then retried from SCAN.
  assign w_conflict     = |((wr_i | del_i) & r_target);
  assign w_commit       = (r_state == ST_COMMIT) && !w_conflict;
  assign learnt_ready_o = (r_state == ST_IDLE) && (!full_o || w_evictAllowed);
  assign learnt_done_o  = w_commit;
  assign learnt_index_o = w_commit ? r_target : '0;

  // Learnt insertion sequencer: latch the clause, pick a slot, then commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_latLen  <= '0;
      r_latLits <= '0;
      r_target  <= '0;
`ifdef CLAUSE_STORE_EVICT_EN
      r_evictPtr    <= '0;
      r_targetEvict <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (learnt_valid_i && learnt_ready_o) begin
            r_latLen  <= learnt_len_i;
            r_latLits <= learnt_lits_i;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (|w_freeOneHot) begin
            r_target <= w_freeOneHot;
`ifdef CLAUSE_STORE_EVICT_EN
            r_targetEvict <= 1'b0;
`endif
            r_state  <= ST_COMMIT;
          end
`ifdef CLAUSE_STORE_EVICT_EN
          else if (|w_victimOneHot) begin
            r_target      <= w_victimOneHot;
            r_targetEvict <= 1'b1;
            r_state       <= ST_COMMIT;
          end
`endif
        end
        ST_COMMIT: begin
          if (w_conflict) begin
            r_state <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
`ifdef CLAUSE_STORE_EVICT_EN
            if (r_targetEvict) r_evictPtr <= w_nextPtr;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Slot arrays. Per slot the base write beats the delete, which beats the
  // learnt commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validMap  <= '0;
      r_learntMap <= '0;
      for (int s = 0; s < N; s++) begin
        r_lenMem[s]  <= '0;
        r_litsMem[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        if (wr_i[s]) begin
          r_validMap[s]  <= 1'b1;
          r_learntMap[s] <= 1'b0;
          r_lenMem[s]    <= clause_len_i;
          r_litsMem[s]   <= clause_lits_i;
        end else if (del_i[s]) begin
          r_validMap[s]  <= 1'b0;
        end else if (w_commit && r_target[s]) begin
          r_validMap[s]  <= 1'b1;
          r_learntMap[s] <= 1'b1;
          r_lenMem[s]    <= r_latLen;
          r_litsMem[s]   <= r_latLits;
        end
      end
    end
  end

  // Registered read port; it samples the arrays before any same-cycle
  // update, so a colliding write returns the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdValid  <= 1'b0;
      r_rdLen    <= '0;
      r_rdLits   <= '0;
      r_rdLearnt <= 1'b0;
    end else begin
      r_rdValid <= rd_en_i;
      if (rd_en_i) begin
        r_rdLen    <= r_lenMem[rd_index_i];
        r_rdLits   <= r_litsMem[rd_index_i];
        r_rdLearnt <= r_learntMap[rd_index_i];
      end
    end
  end

  assign rd_valid_o  = r_rdValid;
  assign rd_len_o    = r_rdLen;
  assign rd_lits_o   = r_rdLits;
  assign rd_learnt_o = r_rdLearnt;

endmodule
